// File: rtl/rob_queue_if.sv
// Bundle of rename-side enqueue, writeback, commit and status signals for rob_queue.
// master drives rename/writeback/flush; slave is the queue itself.
interface rob_queue_if #(
  parameter int DEPTH        = 16,
  parameter int COMMIT_WIDTH = 2,
  parameter int WB_PORTS     = 2,
  parameter int PC_W         = 64,
  parameter int LREG_W       = 5,
  parameter int PREG_W       = 6
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                             enq_valid;
  logic                             enq_ready;
  logic [PC_W-1:0]                  enq_pc;
  logic [31:0]                      enq_instr;
  logic [LREG_W-1:0]                enq_lrd;
  logic [PREG_W-1:0]                enq_prd;
  logic [PREG_W-1:0]                enq_old_prd;
  logic                             enq_need_to_wb;
  logic [IDX_W:0]                   enq_robid;

  logic [WB_PORTS-1:0]              wb_valid;
  logic [WB_PORTS*IDX_W-1:0]        wb_robid;
  logic [WB_PORTS-1:0]              wb_skip;

  logic [COMMIT_WIDTH-1:0]          commit_valid;
  logic [COMMIT_WIDTH*PC_W-1:0]     commit_pc;
  logic [COMMIT_WIDTH*32-1:0]       commit_instr;
  logic [COMMIT_WIDTH*LREG_W-1:0]   commit_lrd;
  logic [COMMIT_WIDTH*PREG_W-1:0]   commit_prd;
  logic [COMMIT_WIDTH*PREG_W-1:0]   commit_old_prd;
  logic [COMMIT_WIDTH-1:0]          commit_need_to_wb;
  logic [COMMIT_WIDTH-1:0]          commit_skip;

  logic                             flush;
  logic [IDX_W:0]                   count;
  logic                             empty;
  logic                             full;

  modport master (
    output enq_valid, enq_pc, enq_instr, enq_lrd, enq_prd, enq_old_prd, enq_need_to_wb,
    input  enq_ready, enq_robid,
    output wb_valid, wb_robid, wb_skip,
    input  commit_valid, commit_pc, commit_instr, commit_lrd, commit_prd, commit_old_prd,
    input  commit_need_to_wb, commit_skip,
    output flush,
    input  count, empty, full
  );

  modport slave (
    input  enq_valid, enq_pc, enq_instr, enq_lrd, enq_prd, enq_old_prd, enq_need_to_wb,
    output enq_ready, enq_robid,
    input  wb_valid, wb_robid, wb_skip,
    output commit_valid, commit_pc, commit_instr, commit_lrd, commit_prd, commit_old_prd,
    output commit_need_to_wb, commit_skip,
    input  flush,
    output count, empty, full
  );
endinterface

// File: rtl/rob_queue.sv
// Circular reorder buffer: single enqueue, WB_PORTS writeback ports, in-order
// retirement of up to COMMIT_WIDTH entries per cycle, single-cycle global flush.
module rob_queue #(
  parameter int DEPTH        = 16,
  parameter int COMMIT_WIDTH = 2,
  parameter int WB_PORTS     = 2,
  parameter int PC_W         = 64,
  parameter int LREG_W       = 5,
  parameter int PREG_W       = 6
) (
  input  logic          clock,
  input  logic          reset,
  rob_queue_if.slave    io
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [31:0]       instr;
    logic [LREG_W-1:0] lrd;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] old_prd;
    logic              need_to_wb;
  } payload_t;

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0]        complete_q, complete_d;
  logic [DEPTH-1:0]        skip_q, skip_d;
  payload_t                payload_q [DEPTH];
  payload_t                payload_d [DEPTH];
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;

  logic [PTR_W-1:0]        count;
  logic                    full;
  logic                    empty;
  logic                    enq_fire;
  logic [IDX_W-1:0]        tail_idx;
  logic [IDX_W-1:0]        slot_idx [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] commit_valid;
  logic [PTR_W-1:0]        ncommit;
  logic [DEPTH-1:0]        wb_hit;
  logic [DEPTH-1:0]        wb_skip_any;

  assign count    = tail_q - head_q;
  assign empty    = (head_q == tail_q);
  assign full     = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign tail_idx = tail_q[IDX_W-1:0];
  assign enq_fire = io.enq_valid & ~full & ~io.flush;

  assign io.enq_ready    = ~full;
  assign io.enq_robid    = tail_q;
  assign io.count        = count;
  assign io.empty        = empty;
  assign io.full         = full;
  assign io.commit_valid = commit_valid;

  genvar gi;
  generate
    for (gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_slot
      assign slot_idx[gi] = head_q[IDX_W-1:0] + IDX_W'(gi);
      assign io.commit_pc[gi*PC_W +: PC_W]         = payload_q[slot_idx[gi]].pc;
      assign io.commit_instr[gi*32 +: 32]          = payload_q[slot_idx[gi]].instr;
      assign io.commit_lrd[gi*LREG_W +: LREG_W]    = payload_q[slot_idx[gi]].lrd;
      assign io.commit_prd[gi*PREG_W +: PREG_W]    = payload_q[slot_idx[gi]].prd;
      assign io.commit_old_prd[gi*PREG_W +: PREG_W] = payload_q[slot_idx[gi]].old_prd;
      assign io.commit_need_to_wb[gi]              = payload_q[slot_idx[gi]].need_to_wb;
      assign io.commit_skip[gi]                    = skip_q[slot_idx[gi]];
    end
  endgenerate

  // A slot retires only if every older slot also retires, keeping commit_valid prefix-contiguous.
  always_comb begin
    logic run;
    run          = 1'b1;
    commit_valid = '0;
    ncommit      = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      run = run & valid_q[slot_idx[i]] & complete_q[slot_idx[i]] & (PTR_W'(i) < count);
      commit_valid[i] = run & ~io.flush;
      ncommit = ncommit + PTR_W'(commit_valid[i]);
    end
  end

  // Ports hitting the same entry merge: complete once, skip flags ORed.
  always_comb begin
    wb_hit      = '0;
    wb_skip_any = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (io.wb_valid[p]) begin
        wb_hit[io.wb_robid[p*IDX_W +: IDX_W]] = 1'b1;
        if (io.wb_skip[p]) begin
          wb_skip_any[io.wb_robid[p*IDX_W +: IDX_W]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    skip_d     = skip_q;
    payload_d  = payload_q;
    head_d     = head_q + ncommit;
    tail_d     = tail_q;

    for (int e = 0; e < DEPTH; e++) begin
      if (wb_hit[e] && valid_q[e]) begin
        complete_d[e] = 1'b1;
        skip_d[e]     = wb_skip_any[e];
      end
    end

    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (commit_valid[i]) begin
        valid_d[slot_idx[i]]    = 1'b0;
        complete_d[slot_idx[i]] = 1'b0;
        skip_d[slot_idx[i]]     = 1'b0;
      end
    end

    // The tail slot is never valid while not full, so writeback cannot collide with it.
    if (enq_fire) begin
      valid_d[tail_idx]            = 1'b1;
      complete_d[tail_idx]         = ~io.enq_need_to_wb;
      skip_d[tail_idx]             = 1'b0;
      payload_d[tail_idx].pc         = io.enq_pc;
      payload_d[tail_idx].instr      = io.enq_instr;
      payload_d[tail_idx].lrd        = io.enq_lrd;
      payload_d[tail_idx].prd        = io.enq_prd;
      payload_d[tail_idx].old_prd    = io.enq_old_prd;
      payload_d[tail_idx].need_to_wb = io.enq_need_to_wb;
      tail_d = tail_q + PTR_W'(1);
    end

    if (io.flush) begin
      valid_d    = '0;
      complete_d = '0;
      skip_d     = '0;
      head_d     = '0;
      tail_d     = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      complete_q <= '0;
      skip_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        payload_q[e] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      complete_q <= complete_d;
      skip_q     <= skip_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      for (int e = 0; e < DEPTH; e++) begin
        payload_q[e] <= payload_d[e];
      end
    end
  end
endmodule

// File: doc/rob_queue.md
Name: rob_queue

Overview:
Parametrised reorder buffer that replaces the per-entry ROB slot with a complete circular queue. It holds DEPTH entries with head and tail pointers, one enqueue port from rename, WB_PORTS writeback ports, and in-order commit of up to COMMIT_WIDTH entries per cycle. It sits between rename/dispatch and the architectural commit logic (freelist release, difftest). Global flush empties it in one cycle.

Parameters:
DEPTH, 16, entry count; power of two, >= 2; IDX_W = $clog2(DEPTH).
COMMIT_WIDTH, 2, max entries retired per cycle; 1..DEPTH.
WB_PORTS, 2, number of writeback ports.
PC_W, 64, PC width.
LREG_W, 5, logical register index width.
PREG_W, 6, physical register index width.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
enq_valid  in  1  rename presents an instruction.
enq_ready  out  1  queue can accept; enqueue fires when enq_valid & enq_ready.
enq_pc  in  PC_W  instruction PC.
enq_instr  in  32  instruction word.
enq_lrd  in  LREG_W  logical destination register.
enq_prd  in  PREG_W  new physical destination register.
enq_old_prd  in  PREG_W  previous mapping of lrd.
enq_need_to_wb  in  1  entry must wait for a writeback before commit.
enq_robid  out  IDX_W+1  tail pointer {wrap, index} allocated to the current enqueue.
wb_valid  in  WB_PORTS  per-port writeback strobe.
wb_robid  in  WB_PORTS*IDX_W  per-port target entry index.
wb_skip  in  WB_PORTS  per-port difftest skip flag.
commit_valid  out  COMMIT_WIDTH  slot i retires this cycle.
commit_pc  out  COMMIT_WIDTH*PC_W  per-slot payload; slot 0 is the oldest entry.
commit_instr  out  COMMIT_WIDTH*32  per-slot payload.
commit_lrd  out  COMMIT_WIDTH*LREG_W  per-slot payload.
commit_prd  out  COMMIT_WIDTH*PREG_W  per-slot payload.
commit_old_prd  out  COMMIT_WIDTH*PREG_W  per-slot payload.
commit_need_to_wb  out  COMMIT_WIDTH  per-slot payload.
commit_skip  out  COMMIT_WIDTH  per-slot payload.
flush  in  1  discard all entries.
count  out  IDX_W+1  number of occupied entries.
empty  out  1  count == 0.
full  out  1  count == DEPTH.

Behaviour:
- State
  - Per entry: valid, complete, skip, plus payload.
  - head_ptr and tail_ptr, each IDX_W+1 bits {wrap, idx}.
  - full when the idx fields are equal and the wrap bits differ; empty when the pointers are equal.
  - count = tail_ptr - head_ptr, modulo 2^(IDX_W+1).
- Reset (synchronous, highest priority)
  - All valid/complete/skip bits and both pointers go to 0; payload goes to 0.
  - Outputs after reset: enq_ready=1, empty=1, full=0, count=0, commit_valid=0, enq_robid=0.
- Enqueue
  - enq_ready = ~full. It is registered-state only and does not look at same-cycle commits.
  - On a fire, the entry at tail idx is written: valid=1, complete=~enq_need_to_wb, skip=0, payload captured.
  - tail_ptr increments by 1 next cycle; idx wraps DEPTH-1 -> 0 and toggles the wrap bit.
  - enq_valid while full is ignored, and no state changes.
- Writeback
  - For each port p with wb_valid[p], and if entry wb_robid[p] is valid, set complete=1 and skip=wb_skip[p].
  - A writeback to an invalid entry is ignored.
  - Two ports hitting the same entry in one cycle: complete=1, skip = OR of the two flags.
  - Writeback updates are visible to commit on the next cycle, never in the same cycle.
- Commit (combinational from state)
  - Slot i is valid iff entries head+0 .. head+i are all valid & complete, and i < count.
  - commit_valid is therefore prefix-contiguous (e.g. 2'b10 is illegal).
  - Payload for slot i comes from entry (head idx + i) mod DEPTH.
  - Retired entries clear valid/complete/skip next cycle; head_ptr advances by popcount(commit_valid).
  - Commit and enqueue in the same cycle are allowed. count_next = count + enq_fire - ncommit.
- Flush
  - Synchronous. Clears every valid/complete/skip bit and sets head_ptr = tail_ptr = 0 next cycle.
  - Overrides enqueue, writeback and commit in the same cycle.
  - commit_valid is forced to 0 while flush=1.
  - enq_ready still reflects ~full; an enqueue in the flush cycle is dropped.
- No backpressure on commit: retirement always happens when eligible.

Test Plan:
- DEPTH=4, COMMIT_WIDTH=2: reset, then 4 enqueues with need_to_wb=1 -> enq_robid = 0,1,2,3; count=4; full=1; enq_ready=0; commit_valid=0.
- From the full state, writeback robid 1 then robid 0 on later cycles -> no commit after robid 1; the cycle after the robid 0 writeback, commit_valid=2'b11 with slot0 pc=entry0 and slot1 pc=entry1; next cycle count=2, head=2.
- Enqueue with need_to_wb=0 into an empty queue -> commit_valid=2'b01 exactly one cycle after enqueue; empty=1 the following cycle.
- Wrap: do 6 enqueue/commit pairs -> enq_robid goes 0,1,2,3,4(wrap=1,idx0),5; payload order preserved across the wrap; count never exceeds 4.
- Same cycle: both WB ports target robid 2 with skip=0 and skip=1 -> at commit, commit_skip=1. Also: writeback to an invalid robid -> no state change.
- Flush with 3 entries, 2 complete, asserted together with enq_valid and a writeback -> commit_valid=0 that cycle; next cycle count=0, empty=1, enq_robid=0; the dropped enqueue never commits.
